// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

  localparam int unsigned DataBits = 8;

  // Mid-bit sample offset within one bit period.
  function automatic int unsigned sample_offset(input int unsigned clks_per_bit);
    return clks_per_bit / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: wraps every CLKS_PER_BIT cycles, flags the mid-bit sample point.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic sample_tick
);

  localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] SampleAt = CntW'(sample_offset(CLKS_PER_BIT));

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: held at zero while cleared, otherwise wraps at the end of the bit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sample_tick = ~clear && (cnt_q == SampleAt);

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receive controller: start detect, mid-bit sampling, parity/framing check and a
// valid/ready output register with overrun reporting.
module uart_rx_sequencer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_in,
  output logic [DataBits-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overrun,
  output logic                busy
);

  rx_state_e           state_q, state_d;
  logic                sync1_q, rxs;
  logic [2:0]          bitidx_q, bitidx_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic                perr_q, perr_d;
  logic [DataBits-1:0] rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                parity_err_q, parity_err_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;
  logic                timer_clear, sample_tick, accept;

  // Two-flop synchroniser, preset to the idle-high line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      rxs     <= sync1_q;
    end
  end

  // Timer only runs while a frame is being timed.
  assign timer_clear = (state_q == StIdle) || (state_q == StBreak);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk        (clk),
    .reset      (reset),
    .clear      (timer_clear),
    .sample_tick(sample_tick)
  );

  assign accept = rx_valid_q & rx_ready;

  // Next-state, shift register and delivery logic.
  always_comb begin
    state_d      = state_q;
    bitidx_d     = bitidx_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;

    if (accept) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        bitidx_d = 3'd0;
        if (!rxs) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (sample_tick) begin
          state_d = rxs ? StIdle : StData;
        end
      end
      StData: begin
        if (sample_tick) begin
          shift_d  = {rxs, shift_q[DataBits-1:1]};
          bitidx_d = bitidx_q + 3'd1;
          if (bitidx_q == 3'd7) begin
            state_d = StParity;
          end
        end
      end
      StParity: begin
        if (sample_tick) begin
          perr_d  = (^{shift_q, rxs}) != PARITY_ODD;
          state_d = StStop;
        end
      end
      StStop: begin
        if (sample_tick) begin
          // A full output register that is not being drained this cycle loses the new frame.
          if (!rx_valid_q || accept) begin
            rx_data_d    = shift_q;
            parity_err_d = perr_q;
            frame_err_d  = ~rxs;
            rx_valid_d   = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
          state_d = rxs ? StIdle : StBreak;
        end
      end
      StBreak: begin
        if (rxs) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      bitidx_q     <= 3'd0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitidx_q     <= bitidx_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer (16 clocks per bit); an odd-parity copy shares the line.
module tb_uart_rx_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic       rx_ready;
  logic       ready_odd;
  logic [7:0] rx_data, rx_data_odd;
  logic       rx_valid, rx_valid_odd;
  logic       parity_err, parity_err_odd;
  logic       frame_err, frame_err_odd;
  logic       overrun, overrun_odd;
  logic       busy, busy_odd;

  uart_rx_sequencer #(
    .CLKS_PER_BIT(16),
    .PARITY_ODD  (1'b0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  uart_rx_sequencer #(
    .CLKS_PER_BIT(16),
    .PARITY_ODD  (1'b1)
  ) dut_odd (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx_in),
    .rx_data   (rx_data_odd),
    .rx_valid  (rx_valid_odd),
    .rx_ready  (ready_odd),
    .parity_err(parity_err_odd),
    .frame_err (frame_err_odd),
    .overrun   (overrun_odd),
    .busy      (busy_odd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         failures = 0;
  int         c0 = 0;
  int         valid_cycles = 0;
  int         rise_cyc = -1;
  int         ovr_cnt = 0;
  int         ovr_cyc = -1;
  logic       valid_d = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic       last_perr = 1'b0;
  logic       last_ferr = 1'b0;
  logic       odd_perr = 1'b0;

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cycles++;
      if (!valid_d) rise_cyc = cyc;
      last_data = rx_data;
      last_perr = parity_err;
      last_ferr = frame_err;
    end
    valid_d = rx_valid;
    if (overrun) begin
      ovr_cnt++;
      ovr_cyc = cyc;
    end
    if (rx_valid_odd) odd_perr = parity_err_odd;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one frame, 16 clocks per bit; must be called on a falling edge.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    rx_in = 1'b0;
    c0    = cyc;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (16) @(negedge clk);
    end
    rx_in = p;
    repeat (16) @(negedge clk);
    rx_in = stop;
    repeat (16) @(negedge clk);
  endtask

  int v0;
  int o0;

  initial begin
    reset     = 1'b1;
    rx_in     = 1'b1;
    rx_ready  = 1'b1;
    ready_odd = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_data", {24'd0, rx_data}, 32'd0);
    check_eq("reset_flags", {30'd0, parity_err, frame_err}, 32'd0);
    check_eq("reset_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Clean 0xA5 frame, even parity bit 0.
    v0 = valid_cycles;
    send_frame(8'hA5, 1'b0, 1'b1);
    check_eq("a5_data", {24'd0, last_data}, 32'hA5);
    check_eq("a5_perr", {31'd0, last_perr}, 32'd0);
    check_eq("a5_ferr", {31'd0, last_ferr}, 32'd0);
    check_eq("a5_rise_cyc", rise_cyc, c0 + 171);
    check_eq("a5_valid_len", valid_cycles - v0, 32'd1);
    check_eq("a5_idle", {31'd0, busy}, 32'd0);
    check_eq("a5_odd_perr", {31'd0, odd_perr}, 32'd1);
    repeat (3) @(negedge clk);

    // 0x01 with parity bit 0: wrong for even, right for odd.
    send_frame(8'h01, 1'b0, 1'b1);
    check_eq("p01_data", {24'd0, last_data}, 32'h01);
    check_eq("p01_perr_even", {31'd0, last_perr}, 32'd1);
    check_eq("p01_perr_odd", {31'd0, odd_perr}, 32'd0);
    repeat (3) @(negedge clk);

    // Five-cycle glitch rejected at the start-bit sample.
    v0    = valid_cycles;
    rx_in = 1'b0;
    c0    = cyc;
    repeat (5) @(negedge clk);
    rx_in = 1'b1;
    while (cyc < c0 + 10) @(negedge clk);
    check_eq("glitch_busy_hold", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_eq("glitch_busy_fall", {31'd0, busy}, 32'd0);
    repeat (10) @(negedge clk);
    check_eq("glitch_no_valid", valid_cycles - v0, 32'd0);
    send_frame(8'hC3, 1'b0, 1'b1);
    check_eq("post_glitch_data", {24'd0, last_data}, 32'hC3);
    check_eq("post_glitch_perr", {31'd0, last_perr}, 32'd0);
    repeat (3) @(negedge clk);

    // Stop bit 0 followed by a held-low line: frame error, then break.
    v0 = valid_cycles;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (24) @(negedge clk);
    check_eq("brk_data", {24'd0, last_data}, 32'h3C);
    check_eq("brk_ferr", {31'd0, last_ferr}, 32'd1);
    check_eq("brk_perr", {31'd0, last_perr}, 32'd0);
    check_eq("brk_rise_cyc", rise_cyc, c0 + 171);
    check_eq("brk_busy", {31'd0, busy}, 32'd1);
    check_eq("brk_one_frame", valid_cycles - v0, 32'd1);
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("brk_busy_late", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    check_eq("brk_idle", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);

    // Consumer stalled: second frame overruns, first byte retained.
    rx_ready = 1'b0;
    o0       = ovr_cnt;
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    check_eq("ovr_data", {24'd0, rx_data}, 32'h11);
    check_eq("ovr_valid", {31'd0, rx_valid}, 32'd1);
    check_eq("ovr_count", ovr_cnt - o0, 32'd1);
    check_eq("ovr_cyc", ovr_cyc, c0 + 171);

    // Reset mid-frame with a pending byte, then a clean frame.
    rx_in = 1'b0;
    c0    = cyc;
    while (cyc < c0 + 83) @(negedge clk);
    check_eq("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rst_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_data", {24'd0, rx_data}, 32'd0);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    reset    = 1'b0;
    rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b1);
    check_eq("5a_data", {24'd0, last_data}, 32'h5A);
    check_eq("5a_flags", {30'd0, last_perr, last_ferr}, 32'd0);
    check_eq("5a_rise_cyc", rise_cyc, c0 + 171);
    check_eq("5a_accepted", {31'd0, rx_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
